// File: rtl/cm_config_loader_if.sv
// cm_config_loader_if: valid/ready configuration stream feeding cm_config_loader.
// The master modport is the packet source; the slave modport is the loader.
interface cm_config_loader_if #(
   parameter int CM_WIDTH = 64
) ();

   logic                cfg_valid;
   logic                cfg_ready;
   logic [CM_WIDTH-1:0] cfg_data;
   logic                cfg_last;

   modport master (
      output cfg_valid,
      output cfg_data,
      output cfg_last,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_data,
      input  cfg_last,
      output cfg_ready
   );

endinterface

// File: rtl/cm_config_loader.sv
// cm_config_loader: decodes configuration packets from a valid/ready stream and
// drives per-tile control-memory writes (one payload word per cycle), plus the
// start_exec hand-over to the PE array.
// Optional build macro: CM_CFG_PARITY_EN -- header bit 61 must be the even parity
// of bits 60:0; a mismatching header is treated as an invalid tile.
module cm_config_loader #(
   parameter int NUM_TILES     = 36,
   parameter int CM_WIDTH      = 64,
   parameter int CM_DEPTH_BITS = 4,
   parameter int TILE_ID_BITS  = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   cm_config_loader_if.slave        cfg,
   output logic [CM_WIDTH-1:0]      cm_data,
   output logic [NUM_TILES-1:0]     cm_en,
   output logic [CM_WIDTH-1:0]      cm_bit_en,
   output logic [CM_DEPTH_BITS-1:0] cm_addr,
   output logic                     read_write,
   output logic                     start_exec,
   output logic                     busy,
   output logic                     err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_START = 2'b01;
   localparam logic [1:0] OP_STOP  = 2'b10;
   localparam logic [1:0] OP_CLR   = 2'b11;

   localparam logic [NUM_TILES-1:0]     TILE_ONE = {{(NUM_TILES-1){1'b0}}, 1'b1};
   localparam logic [CM_DEPTH_BITS-1:0] ADDR_ONE = {{(CM_DEPTH_BITS-1){1'b0}}, 1'b1};

   // FSM and datapath state
   state_t                   state_r;
   state_t                   state_nxt_s;
   logic [TILE_ID_BITS-1:0]  tile_r,  tile_nxt_s;
   logic                     bcast_r, bcast_nxt_s;
   logic [CM_DEPTH_BITS-1:0] addr_r,  addr_nxt_s;
   logic [3:0]               cnt_r,   cnt_nxt_s;
   logic                     start_nxt_s;
   logic                     err_set_s;
   logic                     err_clr_s;
   logic                     wr_s;

   // Registered outputs and their next values
   logic                     cfg_ready_r;
   logic [CM_WIDTH-1:0]      cm_data_r,    cm_data_nxt_s;
   logic [NUM_TILES-1:0]     cm_en_r,      cm_en_nxt_s;
   logic [CM_WIDTH-1:0]      cm_bit_en_r;
   logic [CM_DEPTH_BITS-1:0] cm_addr_r,    cm_addr_nxt_s;
   logic                     read_write_r, read_write_nxt_s;
   logic                     start_exec_r;
   logic                     busy_r,       busy_nxt_s;
   logic                     err_r,        err_nxt_s;

   // Header decode
   logic                     hs_s;
   logic [1:0]               hdr_op_s;
   logic                     hdr_bcast_s;
   logic [3:0]               hdr_cnt_s;
   logic [CM_DEPTH_BITS-1:0] hdr_base_s;
   logic [TILE_ID_BITS-1:0]  hdr_tile_s;
   logic                     hdr_tile_ok_s;
   logic                     hdr_par_ok_s;

   assign hs_s          = cfg.cfg_valid & cfg_ready_r;
   assign hdr_op_s      = cfg.cfg_data[63:62];
   assign hdr_bcast_s   = cfg.cfg_data[16];
   assign hdr_cnt_s     = cfg.cfg_data[15:12];
   assign hdr_base_s    = cfg.cfg_data[8 +: CM_DEPTH_BITS];
   assign hdr_tile_s    = cfg.cfg_data[TILE_ID_BITS-1:0];
   assign hdr_tile_ok_s = hdr_bcast_s | (32'(hdr_tile_s) < NUM_TILES);

`ifdef CM_CFG_PARITY_EN
   function automatic logic even_parity(input logic [60:0] bits);
      return ^bits;
   endfunction

   assign hdr_par_ok_s = (cfg.cfg_data[61] == even_parity(cfg.cfg_data[60:0]));
`else
   assign hdr_par_ok_s = 1'b1;
`endif

   assign cfg.cfg_ready = cfg_ready_r;
   assign cm_data       = cm_data_r;
   assign cm_en         = cm_en_r;
   assign cm_bit_en     = cm_bit_en_r;
   assign cm_addr       = cm_addr_r;
   assign read_write    = read_write_r;
   assign start_exec    = start_exec_r;
   assign busy          = busy_r;
   assign err           = err_r;

   // State register: FSM state, packet context and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         tile_r       <= {TILE_ID_BITS{1'b0}};
         bcast_r      <= 1'b0;
         addr_r       <= {CM_DEPTH_BITS{1'b0}};
         cnt_r        <= 4'd0;
         cfg_ready_r  <= 1'b0;
         cm_data_r    <= {CM_WIDTH{1'b0}};
         cm_en_r      <= {NUM_TILES{1'b1}};
         cm_bit_en_r  <= {CM_WIDTH{1'b1}};
         cm_addr_r    <= {CM_DEPTH_BITS{1'b0}};
         read_write_r <= 1'b0;
         start_exec_r <= 1'b0;
         busy_r       <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         tile_r       <= tile_nxt_s;
         bcast_r      <= bcast_nxt_s;
         addr_r       <= addr_nxt_s;
         cnt_r        <= cnt_nxt_s;
         cfg_ready_r  <= 1'b1;
         cm_data_r    <= cm_data_nxt_s;
         cm_en_r      <= cm_en_nxt_s;
         cm_bit_en_r  <= {CM_WIDTH{1'b1}};
         cm_addr_r    <= cm_addr_nxt_s;
         read_write_r <= read_write_nxt_s;
         start_exec_r <= start_nxt_s;
         busy_r       <= busy_nxt_s;
         err_r        <= err_nxt_s;
      end
   end

   // Next-state logic: header decode, payload sequencing and error detection
   always_comb begin
      state_nxt_s = state_r;
      tile_nxt_s  = tile_r;
      bcast_nxt_s = bcast_r;
      addr_nxt_s  = addr_r;
      cnt_nxt_s   = cnt_r;
      start_nxt_s = start_exec_r;
      err_set_s   = 1'b0;
      err_clr_s   = 1'b0;
      wr_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (hs_s) begin
               if (!hdr_par_ok_s) begin
                  err_set_s   = 1'b1;
                  state_nxt_s = cfg.cfg_last ? ST_IDLE : ST_DRAIN;
               end else begin
                  case (hdr_op_s)
                     OP_WRITE: begin
                        if (start_exec_r || !hdr_tile_ok_s) begin
                           err_set_s   = 1'b1;
                           state_nxt_s = cfg.cfg_last ? ST_IDLE : ST_DRAIN;
                        end else if (cfg.cfg_last) begin
                           // Header-only write packet: nothing to write
                           err_set_s   = 1'b1;
                           state_nxt_s = ST_IDLE;
                        end else begin
                           tile_nxt_s  = hdr_tile_s;
                           bcast_nxt_s = hdr_bcast_s;
                           addr_nxt_s  = hdr_base_s;
                           cnt_nxt_s   = hdr_cnt_s;
                           state_nxt_s = ST_WRITE;
                        end
                     end
                     OP_START: begin
                        if (cfg.cfg_last) begin
                           start_nxt_s = 1'b1;
                           state_nxt_s = ST_RUN;
                        end else begin
                           err_set_s   = 1'b1;
                           state_nxt_s = ST_DRAIN;
                        end
                     end
                     OP_STOP: begin
                        if (cfg.cfg_last) begin
                           start_nxt_s = 1'b0;
                           state_nxt_s = ST_IDLE;
                        end else begin
                           err_set_s   = 1'b1;
                           state_nxt_s = ST_DRAIN;
                        end
                     end
                     OP_CLR: begin
                        if (cfg.cfg_last) begin
                           err_clr_s   = 1'b1;
                           state_nxt_s = ST_IDLE;
                        end else begin
                           err_set_s   = 1'b1;
                           state_nxt_s = ST_DRAIN;
                        end
                     end
                     default: begin
                        err_set_s   = 1'b1;
                        state_nxt_s = ST_DRAIN;
                     end
                  endcase
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (hs_s) begin
               wr_s       = 1'b1;
               addr_nxt_s = addr_r + ADDR_ONE;
               cnt_nxt_s  = cnt_r - 4'd1;
               if (cnt_r == 4'd0) begin
                  // Final counted word: it must also close the packet
                  err_set_s   = ~cfg.cfg_last;
                  state_nxt_s = cfg.cfg_last ? ST_IDLE : ST_DRAIN;
               end else if (cfg.cfg_last) begin
                  // Packet ended early; the word is still written
                  err_set_s   = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_WRITE;
               end
            end else begin
               state_nxt_s = ST_WRITE;
            end
         end
         ST_DRAIN: begin
            if (hs_s && cfg.cfg_last) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         ST_RUN: begin
            if (hs_s) begin
               if (hdr_par_ok_s && (hdr_op_s == OP_STOP) && cfg.cfg_last) begin
                  start_nxt_s = 1'b0;
                  state_nxt_s = ST_IDLE;
               end else begin
                  // Anything but a clean STOP is refused; execution continues
                  err_set_s   = 1'b1;
                  state_nxt_s = cfg.cfg_last ? ST_RUN : ST_DRAIN;
               end
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output logic: next values of the control-memory write port, busy and err
   always_comb begin
      cm_en_nxt_s      = {NUM_TILES{1'b1}};
      read_write_nxt_s = 1'b0;
      cm_data_nxt_s    = cm_data_r;
      cm_addr_nxt_s    = cm_addr_r;
      if (wr_s) begin
         cm_en_nxt_s      = bcast_r ? {NUM_TILES{1'b0}} : ~(TILE_ONE << tile_r);
         read_write_nxt_s = 1'b1;
         cm_data_nxt_s    = cfg.cfg_data;
         cm_addr_nxt_s    = addr_r;
      end else begin
         cm_en_nxt_s      = {NUM_TILES{1'b1}};
         read_write_nxt_s = 1'b0;
      end
      busy_nxt_s = (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_DRAIN);
      if (err_set_s) begin
         err_nxt_s = 1'b1;
      end else if (err_clr_s) begin
         err_nxt_s = 1'b0;
      end else begin
         err_nxt_s = err_r;
      end
   end

endmodule
